crp16_alu_sub_seq: RTL and testbench

CRP16_ALU_SUB_SEQ -- requirements
Module: crp16_alu_sub_seq

---
 rtl/crp16_alu_sub_seq.sv | 131 +++++++++++++
 tb/tb_crp16_alu_sub_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/crp16_alu_sub_seq.sv
// Nibble-serial 16-bit add/subtract unit for the CRP16 set-less-than path.
// Optional feature: define CRP16_ALU_SUB_SEQ_OVF_EN to add the registered signed-overflow output ovf.
module crp16_alu_sub_seq (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        sub,
    input  logic [15:0] x,
    input  logic [15:0] y,
    output logic        busy,
    output logic        done,
    output logic [15:0] z,
    output logic        x_s,
    output logic        y_s,
    output logic        z_s,
`ifdef CRP16_ALU_SUB_SEQ_OVF_EN
    output logic        ovf,
`endif
    output logic        c_out
);

    localparam int unsigned W  = 16;
    localparam int unsigned SW = 4;
    localparam int unsigned CW = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   cnt;
    logic            carry;
    logic            sub_r;
    logic [W-1:0]    xr;
    logic [W-1:0]    yr;

    logic            accept;
    logic            last;
    logic [3:0]      base;
    logic [SW-1:0]   xa;
    logic [SW-1:0]   yb;
    logic [SW:0]     sum;

    // Slice datapath: one 4-bit adder fed by the counter-selected nibbles.
    always_comb begin
        base   = {cnt, 2'b00};
        xa     = xr[base +: SW];
        yb     = yr[base +: SW] ^ {SW{sub_r}};
        sum    = {1'b0, xa} + {1'b0, yb} + {{SW{1'b0}}, carry};
        accept = start && ((state == IDLE) || (state == DONE));
        last   = (state == RUN) && (cnt == CW'(3));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (cnt == CW'(3)) state_nx = DONE;
            DONE:    state_nx = start ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand latch, slice writes and result flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            carry <= 1'b0;
            sub_r <= 1'b0;
            xr    <= '0;
            yr    <= '0;
            z     <= '0;
            x_s   <= 1'b0;
            y_s   <= 1'b0;
            z_s   <= 1'b0;
            c_out <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            busy <= (state_nx == RUN);
            done <= (state_nx == DONE);
            if (accept) begin
                xr    <= x;
                yr    <= y;
                sub_r <= sub;
                carry <= sub;
                cnt   <= '0;
                z     <= '0;
            end else if (state == RUN) begin
                z[base +: SW] <= sum[SW-1:0];
                carry         <= sum[SW];
                cnt           <= cnt + CW'(1);
                if (last) begin
                    x_s   <= xr[W-1];
                    y_s   <= yr[W-1];
                    z_s   <= sum[SW-1];
                    c_out <= sum[SW];
                end
            end
        end
    end

`ifdef CRP16_ALU_SUB_SEQ_OVF_EN
    logic c_msb;

    // Carry into bit 15 recovered from the top bit of the slice-3 sum.
    always_comb begin
        c_msb = xa[SW-1] ^ yb[SW-1] ^ sum[SW-1];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf <= 1'b0;
        end else if (last) begin
            ovf <= c_msb ^ sum[SW];
        end
    end
`endif

endmodule

// File: tb/tb_crp16_alu_sub_seq.sv
// Directed bench for crp16_alu_sub_seq; covers ovf when CRP16_ALU_SUB_SEQ_OVF_EN is defined.
module tb_crp16_alu_sub_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        sub;
    logic [15:0] x;
    logic [15:0] y;
    logic        busy;
    logic        done;
    logic [15:0] z;
    logic        x_s;
    logic        y_s;
    logic        z_s;
    logic        c_out;
`ifdef CRP16_ALU_SUB_SEQ_OVF_EN
    logic        ovf;
`endif

    int total = 0;
    int bad   = 0;

    crp16_alu_sub_seq dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .sub     (sub),
        .x       (x),
        .y       (y),
        .busy    (busy),
        .done    (done),
        .z       (z),
        .x_s     (x_s),
        .y_s     (y_s),
        .z_s     (z_s),
`ifdef CRP16_ALU_SUB_SEQ_OVF_EN
        .ovf     (ovf),
`endif
        .c_out   (c_out)
    );

    always #5 clk = ~clk;

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op from the current cycle and return edges until done (20 = timed out).
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s, output int lat);
        x     = a;
        y     = b;
        sub   = s;
        start = 1'b1;
        lat   = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            lat++;
            if (lat == 1) begin
                start = 1'b0;
                x     = ~a;
                y     = ~b;
                sub   = ~s;
            end
            if (done) break;
        end
    endtask

    int          lat;
    int          ndone;
    int          first;
    logic [15:0] zd;

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        sub     = 1'b0;
        x       = '0;
        y       = '0;
        #2;
        chk16("rst_z", z, 16'h0000);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_c_out", c_out, 1'b0);
        chk1("rst_flags", x_s | y_s | z_s, 1'b0);
`ifdef CRP16_ALU_SUB_SEQ_OVF_EN
        chk1("rst_ovf", ovf, 1'b0);
`endif
        step();
        step();
        reset_n = 1'b1;

        // 3 - 5 borrows
        run_op(16'h0003, 16'h0005, 1'b1, lat);
        chk16("borrow_lat", 16'(lat), 16'd5);
        chk16("borrow_z", z, 16'hFFFE);
        chk1("borrow_c_out", c_out, 1'b0);
        chk1("borrow_z_s", z_s, 1'b1);
        chk1("borrow_x_s", x_s, 1'b0);
        chk1("borrow_y_s", y_s, 1'b0);
        chk1("borrow_busy", busy, 1'b0);
`ifdef CRP16_ALU_SUB_SEQ_OVF_EN
        chk1("borrow_ovf", ovf, 1'b0);
`endif
        step();
        chk1("hold_done", done, 1'b0);
        chk16("hold_z", z, 16'hFFFE);
        chk1("hold_z_s", z_s, 1'b1);

        // 0x8000 - 1 overflows signed range
        run_op(16'h8000, 16'h0001, 1'b1, lat);
        chk16("ovf_lat", 16'(lat), 16'd5);
        chk16("ovf_z", z, 16'h7FFF);
        chk1("ovf_c_out", c_out, 1'b1);
        chk1("ovf_x_s", x_s, 1'b1);
        chk1("ovf_y_s", y_s, 1'b0);
        chk1("ovf_z_s", z_s, 1'b0);
`ifdef CRP16_ALU_SUB_SEQ_OVF_EN
        chk1("ovf_ovf", ovf, 1'b1);
`endif
        step();

        // 0xFFFF + 1 wraps
        run_op(16'hFFFF, 16'h0001, 1'b0, lat);
        chk16("wrap_lat", 16'(lat), 16'd5);
        chk16("wrap_z", z, 16'h0000);
        chk1("wrap_c_out", c_out, 1'b1);
        chk1("wrap_z_s", z_s, 1'b0);
`ifdef CRP16_ALU_SUB_SEQ_OVF_EN
        chk1("wrap_ovf", ovf, 1'b0);
`endif
        step();

        // start pulsed during RUN cycle 2 must be ignored
        x     = 16'h0100;
        y     = 16'h0023;
        sub   = 1'b0;
        start = 1'b1;
        ndone = 0;
        first = 0;
        zd    = '0;
        for (int i = 1; i <= 12; i++) begin
            step();
            start = 1'b0;
            if (i == 2) begin
                start = 1'b1;
                x     = 16'h1234;
                y     = 16'h0001;
            end
            if (done) begin
                ndone++;
                if (first == 0) first = i;
                zd = z;
            end
        end
        chk16("ign_ndone", 16'(ndone), 16'd1);
        chk16("ign_lat", 16'(first), 16'd5);
        chk16("ign_z", zd, 16'h0123);

        // back-to-back: start held at DONE
        run_op(16'h0007, 16'h0002, 1'b1, lat);
        chk16("b2b_a_lat", 16'(lat), 16'd5);
        chk16("b2b_a_z", z, 16'h0005);
        chk1("b2b_a_c_out", c_out, 1'b1);
        chk1("b2b_a_done", done, 1'b1);
        run_op(16'h1111, 16'h2222, 1'b0, lat);
        chk16("b2b_b_lat", 16'(lat), 16'd5);
        chk16("b2b_b_z", z, 16'h3333);
        chk1("b2b_b_c_out", c_out, 1'b0);
        step();

        // reset asserted on RUN cycle 3
        x     = 16'h8811;
        y     = 16'h8822;
        sub   = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk1("mid_busy", busy, 1'b1);
        reset_n = 1'b0;
        #1;
        chk16("mid_rst_z", z, 16'h0000);
        chk1("mid_rst_busy", busy, 1'b0);
        chk1("mid_rst_done", done, 1'b0);
        chk1("mid_rst_c_out", c_out, 1'b0);
        chk1("mid_rst_flags", x_s | y_s | z_s, 1'b0);
`ifdef CRP16_ALU_SUB_SEQ_OVF_EN
        chk1("mid_rst_ovf", ovf, 1'b0);
`endif
        step();
        chk1("mid_rst_nodone1", done, 1'b0);
        step();
        chk1("mid_rst_nodone2", done, 1'b0);
        reset_n = 1'b1;
        run_op(16'h0010, 16'h0010, 1'b1, lat);
        chk16("post_rst_lat", 16'(lat), 16'd5);
        chk16("post_rst_z", z, 16'h0000);
        chk1("post_rst_c_out", c_out, 1'b1);
        chk1("post_rst_z_s", z_s, 1'b0);
`ifdef CRP16_ALU_SUB_SEQ_OVF_EN
        chk1("post_rst_ovf", ovf, 1'b0);
`endif
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
